// File: rtl/muladd_pkg.sv
// Shared state encoding and width constants for muladd32.
// Defining MULADD32_RADIX4_EN switches the datapath to radix-4 (2 multiplier bits per step).
package muladd_pkg;

  localparam int unsigned K_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ADD,
    DONE
  } state_t;

`ifdef MULADD32_RADIX4_EN
  localparam int unsigned STEP_BITS = 2;
`else
  localparam int unsigned STEP_BITS = 1;
`endif

endpackage

// File: rtl/muladd_step.sv
// One shift-add step of the MSB-first multiplier: acc_nxt = (acc << STEP_BITS) + q_top * d.
// MULADD32_RADIX4_EN selects the radix-4 form (partial product 0, d, 2d or 3d).
module muladd_step
  import muladd_pkg::*;
#(
  parameter int unsigned K = K_DEF
) (
  input  logic [2*K-1:0]       acc,
  input  logic [K-1:0]         d,
  input  logic [STEP_BITS-1:0] q_top,
  output logic [2*K-1:0]       acc_nxt
);

  logic [2*K-1:0] d_ext;

  assign d_ext = {{K{1'b0}}, d};

`ifdef MULADD32_RADIX4_EN
  logic [2*K-1:0] pp;

  always_comb begin
    pp = '0;
    case (q_top)
      2'd0:    pp = '0;
      2'd1:    pp = d_ext;
      2'd2:    pp = d_ext << 1;
      default: pp = (d_ext << 1) + d_ext;
    endcase
    acc_nxt = (acc << 2) + pp;
  end
`else
  always_comb begin
    acc_nxt = (acc << 1) + (q_top[0] ? d_ext : '0);
  end
`endif

endmodule

// File: rtl/muladd32.sv
// Sequential reconstruction of a dividend: x = q*d + r, unsigned, 2K-bit result.
// MULADD32_RADIX4_EN retires two q bits per BUSY cycle instead of one.
module muladd32
  import muladd_pkg::*;
#(
  parameter int unsigned K = K_DEF
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [K-1:0]   q,
  input  logic [K-1:0]   d,
  input  logic [K-1:0]   r,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*K-1:0] x
);

  localparam int unsigned ITERS = K / STEP_BITS;
  localparam int unsigned CW    = $clog2(ITERS + 1);
  localparam logic [CW-1:0] ITERS_C = CW'(ITERS);

  state_t         state, state_nxt;
  logic [2*K-1:0] acc, acc_step;
  logic [K-1:0]   q_sh, d_r, r_r;
  logic [CW-1:0]  cnt;
  logic           iters_done;

  assign iters_done = (cnt == ITERS_C);

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // BUSY stays one extra cycle after the last iteration: the exit is taken on the
  // edge where the counter already reads ITERS, giving ITERS+2 edges accept-to-valid.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: if (iters_done) state_nxt = ADD;
      ADD:  state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  muladd_step #(.K(K)) u_step (
    .acc    (acc),
    .d      (d_r),
    .q_top  (q_sh[K-1 -: STEP_BITS]),
    .acc_nxt(acc_step)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc  <= '0;
      q_sh <= '0;
      d_r  <= '0;
      r_r  <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            q_sh <= q;
            d_r  <= d;
            r_r  <= r;
            acc  <= '0;
            cnt  <= '0;
          end
        end
        BUSY: begin
          if (!iters_done) begin
            acc  <= acc_step;
            q_sh <= q_sh << STEP_BITS;
            cnt  <= cnt + 1'b1;
          end
        end
        ADD:     acc <= acc + {{K{1'b0}}, r_r};
        default: ;
      endcase
    end
  end

  assign x = acc;

endmodule

// File: doc/muladd32.md
MULADD32 -- requirements
Module: muladd32

Interface
REQ-001 SHALL have parameter K, default 32, meaning operand width; x is 2K bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand set q/d/r valid.
REQ-005 SHALL have port in_ready  output  1  block idle, can accept operands.
REQ-006 SHALL have port q  input  K  quotient (multiplier).
REQ-007 SHALL have port d  input  K  divisor (multiplicand).
REQ-008 SHALL have port r  input  K  remainder (addend), any value, not required < d.
REQ-009 SHALL have port out_valid  output  1  result x valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts x.
REQ-011 SHALL have port x  output  2K  reconstructed dividend x = q*d + r, unsigned.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, ADD, DONE.
REQ-013 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE (both registered-state decodes).
REQ-014 SHALL, in IDLE on in_valid&&in_ready at an edge, capture q, d, r, clear accumulator, clear iteration counter, go to BUSY.
REQ-015 SHALL, each BUSY edge, compute acc <= (acc << 1) + (q_msb ? d : 0), shift captured q left by 1, increment counter; MSB-first.
REQ-016 SHALL leave BUSY for ADD after exactly K iterations (radix-2).
REQ-017 SHALL, in ADD, compute acc <= acc + zero-extended r and go to DONE.
REQ-018 SHALL yield out_valid K+2 edges after the accepting edge (K=32: 34 edges) in radix-2 mode.
REQ-019 SHALL hold x and out_valid stable in DONE while out_ready = 0.
REQ-020 SHALL go DONE -> IDLE on out_ready = 1; in_ready rises the following cycle (no same-cycle accept).
REQ-021 SHALL ignore in_valid and input changes outside IDLE; captured operands are used.
REQ-022 SHALL drive x from the accumulator register only; x retains last result after returning to IDLE.
REQ-023 SHALL use 2K-bit arithmetic; no overflow flag: max (2^K-1)^2 + (2^K-1) < 2^(2K).
REQ-024 SHALL treat q = 0 or d = 0 normally (full iteration count, x = r); no early termination.

Reset
REQ-025 SHALL, with rstn = 0 at an edge, force IDLE, accumulator/x = 0, counter = 0, captured operands = 0; out_valid = 0, in_ready = 1 after that edge.
REQ-026 SHALL abort any in-flight BUSY/ADD/DONE operation on reset with no result produced; rstn dominates in_valid.

Configuration
REQ-027 SHALL, with macro MULADD32_RADIX4_EN defined, retire 2 q bits per BUSY edge: acc <= (acc << 2) + q[K-1:K-2]*d (0, d, 2d, 3d), K/2 iterations, out_valid K/2+2 edges after accept (K=32: 18).
REQ-028 SHALL, without MULADD32_RADIX4_EN, use radix-2 per REQ-015..018; K SHALL be even when the macro is defined.

Structure
REQ-029 SHALL place state enum (IDLE/BUSY/ADD/DONE) and default width constant K_DEF = 32 in shared package muladd_pkg.
REQ-030 SHALL use one sub-module muladd_step (combinational: acc, d, q top bits -> next acc), instantiated once, radix selected by the macro.

Verification
REQ-031 SHALL test q=3, d=7, r=2 accepted at edge T -> x = 0x17, out_valid first high after edge T+34 (T+18 with macro).
REQ-032 SHALL test q=d=r=0xFFFFFFFF -> x = 0xFFFFFFFF_00000000.
REQ-033 SHALL test q=0, d=0x12345678, r=5 -> x = 5 after full latency; q=1, d=0, r=0 -> x = 0.
REQ-034 SHALL test out_ready low 10 cycles in DONE -> x, out_valid stable, in_ready 0, in_valid pulses ignored; out_ready high -> IDLE next edge.
REQ-035 SHALL test rstn low at 10th BUSY edge -> x = 0, out_valid 0, in_ready 1; next op q=2, d=5, r=1 -> x = 11.
REQ-036 SHALL run 10000 random back-to-back q/d/r with random out_ready -> x equals model q*d + r every transfer.
